// File: rtl/ac_pkg.sv
// ac_pkg: sequencer state encoding and UPSTAT register constants
package ac_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN, ST_WAIT_CLR} ac_state_t;
    localparam int          UPSTAT_ADDR = 0;
    localparam int          UPSTART_BIT = 0;
    localparam int          UPEND_BIT   = 1;
    localparam logic [31:0] UPEND_WORD  = 32'h2;
endpackage

// File: rtl/ac_pixel_counter.sv
// ac_pixel_counter: x/y beat counter with line-end, frame-start and frame-done flags
module ac_pixel_counter #(
    parameter int W = 3840,
    parameter int H = 2160
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_step,
    output logic o_last,
    output logic o_first,
    output logic o_done
);
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_y_last;
    assign o_last   = r_x == XW'(W - 1);
    assign w_y_last = r_y == YW'(H - 1);
    assign o_first  = r_x == '0 && r_y == '0;
    assign o_done   = i_step && o_last && w_y_last;
    // y wraps explicitly so the counter is back at 0,0 after the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_step) begin
            r_x <= o_last ? '0 : r_x + 1'b1;
            if (o_last) r_y <= w_y_last ? '0 : r_y + 1'b1;
        end
    end
endmodule

// File: rtl/ac_frame_sequencer.sv
// ac_frame_sequencer: opens the up-sampling streams for one frame and writes UPEND when it completes
module ac_frame_sequencer
    import ac_pkg::*;
#(
    parameter int CRF_DATA_WIDTH = 32,
    parameter int CRF_ADDR_WIDTH = 32,
    parameter int SRC_W = 960,
    parameter int SRC_H = 540,
    parameter int DST_W = 3840,
    parameter int DST_H = 2160
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      crf_ac_UPSTART,
    input  logic                      crf_ac_UPEND,
    input  logic                      crf_ac_wbusy,
    output logic                      ac_crf_wrt,
    output logic [CRF_ADDR_WIDTH-1:0] ac_crf_waddr,
    output logic [CRF_DATA_WIDTH-1:0] ac_crf_wdata,
    output logic                      ac_crf_processing,
    input  logic                      s_in_tvalid,
    output logic                      s_in_tready,
    input  logic                      core_in_tready,
    input  logic                      core_out_tvalid,
    output logic                      core_out_tready,
    input  logic                      m_out_tready,
    output logic                      m_out_tvalid,
    output logic                      m_out_tlast,
    output logic                      m_out_tuser
);
    localparam int IN_TOT = SRC_W * SRC_H;
    localparam int IW     = $clog2(IN_TOT + 1);
    ac_state_t     r_state, w_next;
    logic [IW-1:0] r_in_cnt;
    logic          r_wrt;
    logic          w_run, w_out_hs, w_last, w_first, w_done;
    ac_pixel_counter #(.W(DST_W), .H(DST_H)) u_out_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (!w_run),
        .i_step (w_out_hs),
        .o_last (w_last),
        .o_first(w_first),
        .o_done (w_done)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     w_next = crf_ac_UPSTART && !crf_ac_UPEND ? ST_RUN : ST_IDLE;
            ST_RUN:      w_next = !crf_ac_UPSTART ? ST_IDLE : w_done ? ST_FIN : ST_RUN;
            ST_FIN:      w_next = crf_ac_wbusy ? ST_FIN : ST_WAIT_CLR;
            ST_WAIT_CLR: w_next = crf_ac_UPEND ? ST_WAIT_CLR : ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end
    always_comb begin
        w_run             = r_state == ST_RUN;
        w_out_hs          = core_out_tvalid && m_out_tready && w_run;
        ac_crf_processing = w_run;
        s_in_tready       = core_in_tready && w_run && (r_in_cnt < IW'(IN_TOT));
        m_out_tvalid      = core_out_tvalid && w_run;
        core_out_tready   = m_out_tready && w_run;
        m_out_tlast       = w_run && w_last;
        m_out_tuser       = w_run && w_first;
        ac_crf_wrt        = r_wrt;
        ac_crf_waddr      = CRF_ADDR_WIDTH'(UPSTAT_ADDR);
        ac_crf_wdata      = r_wrt ? CRF_DATA_WIDTH'(UPEND_WORD) : '0;
    end
    // write request mirrors FIN from a flop so it stays glitch-free toward the register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_wrt <= 1'b0;
        else        r_wrt <= w_next == ST_FIN;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         r_in_cnt <= '0;
        else if (!w_run)                    r_in_cnt <= '0;
        else if (s_in_tvalid && s_in_tready) r_in_cnt <= r_in_cnt + 1'b1;
    end
endmodule

// File: tb/tb_ac_frame_sequencer.sv
// tb_ac_frame_sequencer: gating vectors, scoreboarded output markers and frame-control sequences
module tb_ac_frame_sequencer;
    localparam int SW = 4, SH = 2, DW = 16, DH = 8, NB = DW * DH;
    logic        clk = 0, rst_n = 1;
    logic        ps_we = 0, wbusy = 0;
    logic [31:0] ps_wd = 0, upstat = 0;
    logic        s_in_tvalid = 0, core_in_tready = 0, core_out_tvalid = 0, m_out_tready = 0;
    logic        wrt, processing, s_in_tready, core_out_tready, m_out_tvalid, m_out_tlast, m_out_tuser;
    logic [31:0] waddr, wdata;
    logic [1:0]  exp_m;
    logic [1:0]  q[$];
    int          total = 0, bad = 0, beat_cnt = 0;
    typedef struct {
        logic cin, cov, mr, e_sr, e_mv, e_cr, e_tu;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    ac_frame_sequencer #(.SRC_W(SW), .SRC_H(SH), .DST_W(DW), .DST_H(DH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .crf_ac_UPSTART   (upstat[0]),
        .crf_ac_UPEND     (upstat[1]),
        .crf_ac_wbusy     (wbusy),
        .ac_crf_wrt       (wrt),
        .ac_crf_waddr     (waddr),
        .ac_crf_wdata     (wdata),
        .ac_crf_processing(processing),
        .s_in_tvalid      (s_in_tvalid),
        .s_in_tready      (s_in_tready),
        .core_in_tready   (core_in_tready),
        .core_out_tvalid  (core_out_tvalid),
        .core_out_tready  (core_out_tready),
        .m_out_tready     (m_out_tready),
        .m_out_tvalid     (m_out_tvalid),
        .m_out_tlast      (m_out_tlast),
        .m_out_tuser      (m_out_tuser)
    );

    // register file model: PS writes win, otherwise a PL write lands when not busy
    always @(posedge clk) begin
        if (ps_we) upstat <= ps_wd;
        else if (wrt && !wbusy) upstat <= wdata;
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_out_tvalid && m_out_tready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got beat %0d expected none", beat_cnt);
            end else begin
                exp_m = q.pop_front();
                check("tlast", m_out_tlast, exp_m[1]);
                check("tuser", m_out_tuser, exp_m[0]);
            end
            beat_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ps_write(input logic [31:0] v);
        ps_wd = v;
        ps_we = 1;
        tick();
        ps_we = 0;
    endtask

    task automatic start_frame();
        q.delete();
        beat_cnt = 0;
        for (int i = 0; i < NB; i++) q.push_back({(i % DW) == DW - 1, i == 0});
        ps_write(1);
        tick();
        check("start_proc", processing, 1);
    endtask

    task automatic run_beats(input int n, input bit bp);
        core_out_tvalid = 1;
        for (int c = 0; c < 4000 && beat_cnt < n; c++) begin
            m_out_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            tick();
        end
        m_out_tready = 0;
        check("beats_reached", beat_cnt, n);
    endtask

    task automatic check_all_low(input string nm);
        check({nm, "_wrt"}, wrt, 0);
        check({nm, "_wdata"}, wdata, 0);
        check({nm, "_waddr"}, waddr, 0);
        check({nm, "_proc"}, processing, 0);
        check({nm, "_sin_rdy"}, s_in_tready, 0);
        check({nm, "_core_rdy"}, core_out_tready, 0);
        check({nm, "_mvalid"}, m_out_tvalid, 0);
        check({nm, "_tlast"}, m_out_tlast, 0);
        check({nm, "_tuser"}, m_out_tuser, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, nw, na;
        tbl[0] = '{0, 0, 0, 0, 0, 0, 1};
        tbl[1] = '{1, 0, 0, 1, 0, 0, 1};
        tbl[2] = '{0, 1, 0, 0, 1, 0, 1};
        tbl[3] = '{0, 0, 1, 0, 0, 1, 1};
        tbl[4] = '{1, 1, 0, 1, 1, 0, 1};
        tbl[5] = '{1, 0, 1, 1, 0, 1, 1};
        core_in_tready = 1; core_out_tvalid = 1; m_out_tready = 1; s_in_tvalid = 1;
        #2 rst_n = 0;
        repeat (3) tick();
        check_all_low("rst");
        core_in_tready = 0; core_out_tvalid = 0; m_out_tready = 0; s_in_tvalid = 0;
        rst_n = 1;
        tick();
        // start latency: UPSTAT visible after the write edge, RUN one edge later
        ps_write(1);
        check("start_idle_proc", processing, 0);
        tick();
        check("start_run_proc", processing, 1);
        for (int i = 0; i < 6; i++) begin
            core_in_tready = tbl[i].cin; core_out_tvalid = tbl[i].cov; m_out_tready = tbl[i].mr;
            #1;
            check("vec_sin_rdy", s_in_tready, tbl[i].e_sr);
            check("vec_mvalid", m_out_tvalid, tbl[i].e_mv);
            check("vec_core_rdy", core_out_tready, tbl[i].e_cr);
            check("vec_tuser", m_out_tuser, tbl[i].e_tu);
            check("vec_tlast", m_out_tlast, 0);
            tick();
        end
        // input over-supply closes after SW*SH beats
        s_in_tvalid = 1; core_in_tready = 1; core_out_tvalid = 0; m_out_tready = 0; n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (s_in_tready) n++;
            tick();
        end
        check("in_hs", n, SW * SH);
        check("in_closed", s_in_tready, 0);
        s_in_tvalid = 0;
        // full frame
        q.delete(); beat_cnt = 0;
        for (int i = 0; i < NB; i++) q.push_back({(i % DW) == DW - 1, i == 0});
        run_beats(NB, 0);
        check("sb_empty", q.size(), 0);
        check("fin_wrt", wrt, 1);
        check("fin_wdata", wdata, 2);
        check("fin_waddr", waddr, 0);
        check("fin_proc", processing, 0);
        check("fin_mvalid", m_out_tvalid, 0);
        tick();
        check("done_upstat", upstat, 2);
        check("wc_wrt", wrt, 0);
        tick();
        check("wc_sin_rdy", s_in_tready, 0);
        // abort after 40 beats
        ps_write(0);
        start_frame();
        run_beats(40, 0);
        ps_write(0);
        check("abort_still_run", processing, 1);
        tick();
        m_out_tready = 1; core_out_tvalid = 1; core_in_tready = 1;
        #1;
        check("abort_proc", processing, 0);
        check("abort_mvalid", m_out_tvalid, 0);
        check("abort_core_rdy", core_out_tready, 0);
        check("abort_sin_rdy", s_in_tready, 0);
        check("abort_wrt", wrt, 0);
        tick();
        m_out_tready = 0;
        check("abort_beats", beat_cnt, 40);
        check("abort_upstat", upstat, 0);
        // restart from beat 0 under random back-pressure, then collide the write with wbusy
        start_frame();
        wbusy = 1;
        run_beats(NB, 1);
        check("bp_sb_empty", q.size(), 0);
        nw = 0; na = 0;
        for (int i = 0; i < 6; i++) begin
            wbusy = (i < 3);
            if (wrt) nw++;
            if (wrt && !wbusy) na++;
            tick();
        end
        check("busy_wrt_cycles", nw, 4);
        check("busy_accepts", na, 1);
        check("busy_upstat", upstat, 2);
        // reset in the middle of a frame
        ps_write(0);
        start_frame();
        run_beats(60, 0);
        m_out_tready = 1; core_in_tready = 1; core_out_tvalid = 1;
        rst_n = 0;
        #1;
        check_all_low("midrst");
        ps_write(0);
        rst_n = 1;
        m_out_tready = 0;
        tick();
        start_frame();
        run_beats(NB, 0);
        check("post_rst_wrt", wrt, 1);
        check("post_rst_wdata", wdata, 2);
        tick();
        check("post_rst_upstat", upstat, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
